// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, 2-bit port (MSB first), length code (MSB first),
// len+1 payload bits (LSB first), then GAP_BITS idle-high periods.
// Advances only on clkEn edges; all outputs registered; start is ignored while busy.
module serial_frame_tx #(
  parameter int LEN_W    = 4,
  parameter int DATA_W   = 16,
  parameter int GAP_BITS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clkEn,
  input  logic              start,
  input  logic [1:0]        port_sel,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] data,
  output logic              SerOut,
  output logic              busy,
  output logic              ready,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_PORT,
    S_LEN,
    S_DATA,
    S_GAP
  } state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         port_q, port_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               ser_q, ser_d;
  logic               busy_q, busy_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;
  logic [LEN_W-1:0]   len_sh;

  // Next-state logic: the counter holds the number of bit periods left in the current field
  // after the one now on the line, so a zero count marks the field's final enabled edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    port_d  = port_q;
    len_d   = len_q;
    data_d  = data_q;
    ser_d   = ser_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    len_sh  = len_q >> (cnt_q - 1'b1);
    if (clkEn) begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            port_d  = port_sel;
            len_d   = len;
            data_d  = data;
            ser_d   = 1'b0;
            busy_d  = 1'b1;
            state_d = S_START;
          end
        end
        S_START: begin
          ser_d   = port_q[1];
          cnt_d   = LEN_W'(1);
          state_d = S_PORT;
        end
        S_PORT: begin
          if (cnt_q == '0) begin
            ser_d   = len_q[LEN_W-1];
            cnt_d   = LEN_W'(LEN_W - 1);
            state_d = S_LEN;
          end else begin
            ser_d = port_q[0];
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_LEN: begin
          if (cnt_q == '0) begin
            ser_d   = data_q[0];
            cnt_d   = len_q;
            state_d = S_DATA;
          end else begin
            ser_d = len_sh[0];
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_DATA: begin
          // Shadow data shifts every payload edge so bit 0 is always the bit on the line.
          data_d = data_q >> 1;
          if (cnt_q == '0) begin
            ser_d   = 1'b1;
            cnt_d   = LEN_W'(GAP_BITS - 1);
            state_d = S_GAP;
          end else begin
            ser_d = data_q[1];
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_GAP: begin
          if (cnt_q == '0) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          ser_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      endcase
    end
    ready_d = ~busy_d;
  end

  // State and output registers; reset forces the idle line immediately, even mid-frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      port_q  <= '0;
      len_q   <= '0;
      data_q  <= '0;
      ser_q   <= 1'b1;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      port_q  <= port_d;
      len_q   <= len_d;
      data_q  <= data_d;
      ser_q   <= ser_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign SerOut = ser_q;
  assign busy   = busy_q;
  assign ready  = ready_q;
  assign done   = done_q;

endmodule
